rv_bus_arbiter: RTL and testbench

- Shares the core's single memory bus between instruction fetch (I port, read-only) and the load/store unit (D port, read/write).
- Sits between the fetch/LSU stages and the memory interconnect. It produces the bus acknowledge that feeds the decode stage's instruction latch.
- Registered single-outstanding-transaction arbiter with data-priority, fetch anti-starvation, per-transaction timeout and fetch-flush discard.

---
 rtl/rv_bus_arbiter.sv | 199 +++++++++++++++++++
 tb/tb_rv_bus_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_bus_arbiter.sv
// Single-outstanding-transaction arbiter sharing one memory bus between
// instruction fetch (read-only) and the load/store unit, with registered outputs.
module rv_bus_arbiter #(
  parameter int FETCH_STARVE_MAX = 4,
  parameter int TIMEOUT_CYCLES   = 255
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_flush,
  input  logic        i_ibus_req,
  input  logic [29:0] i_ibus_addr,
  output logic [31:0] o_ibus_data,
  output logic        o_ibus_ack,
  output logic        o_ibus_err,
  input  logic        i_dbus_req,
  input  logic        i_dbus_we,
  input  logic [29:0] i_dbus_addr,
  input  logic [31:0] i_dbus_wdata,
  input  logic [3:0]  i_dbus_sel,
  output logic [31:0] o_dbus_rdata,
  output logic        o_dbus_ack,
  output logic        o_dbus_err,
  output logic        o_bus_req,
  output logic        o_bus_we,
  output logic [29:0] o_bus_addr,
  output logic [31:0] o_bus_wdata,
  output logic [3:0]  o_bus_sel,
  input  logic [31:0] i_bus_rdata,
  input  logic        i_bus_ack
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_I_ACT  = 2'd1;
  localparam logic [1:0] ST_D_ACT  = 2'd2;
  localparam logic [1:0] ST_I_DROP = 2'd3;

  localparam logic [3:0]  STARVE_MAX = 4'(FETCH_STARVE_MAX);
  localparam logic [15:0] TMO_LAST   = 16'(TIMEOUT_CYCLES - 1);

  logic [1:0]  state_q, state_d;
  logic [3:0]  starve_q, starve_d;
  logic [15:0] tmo_q, tmo_d;
  logic        bus_req_q, bus_req_d;
  logic        bus_we_q, bus_we_d;
  logic [29:0] bus_addr_q, bus_addr_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic [3:0]  bus_sel_q, bus_sel_d;
  logic [31:0] ibus_data_q, ibus_data_d;
  logic        ibus_ack_q, ibus_ack_d;
  logic        ibus_err_q, ibus_err_d;
  logic [31:0] dbus_rdata_q, dbus_rdata_d;
  logic        dbus_ack_q, dbus_ack_d;
  logic        dbus_err_q, dbus_err_d;

  logic i_elig, d_elig, done_cycle, timeout_hit;

  assign i_elig      = i_ibus_req && !ibus_ack_q && !ibus_err_q && !i_flush;
  assign d_elig      = i_dbus_req && !dbus_ack_q && !dbus_err_q;
  // No grant at all in a completion cycle, so the loser of the previous
  // arbitration cannot slip in ahead of a continuously requesting winner.
  assign done_cycle  = ibus_ack_q || ibus_err_q || dbus_ack_q || dbus_err_q;
  // Fires in the cycle whose increment would make the count reach TIMEOUT_CYCLES.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (tmo_q == TMO_LAST);

  always_comb begin
    state_d      = state_q;
    starve_d     = starve_q;
    tmo_d        = tmo_q;
    bus_req_d    = bus_req_q;
    bus_we_d     = bus_we_q;
    bus_addr_d   = bus_addr_q;
    bus_wdata_d  = bus_wdata_q;
    bus_sel_d    = bus_sel_q;
    ibus_data_d  = ibus_data_q;
    ibus_ack_d   = 1'b0;
    ibus_err_d   = 1'b0;
    dbus_rdata_d = dbus_rdata_q;
    dbus_ack_d   = 1'b0;
    dbus_err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!done_cycle) begin
          if (i_elig && (!d_elig || starve_q == STARVE_MAX)) begin
            state_d     = ST_I_ACT;
            starve_d    = 4'd0;
            tmo_d       = 16'd0;
            bus_req_d   = 1'b1;
            bus_we_d    = 1'b0;
            bus_addr_d  = i_ibus_addr;
            bus_wdata_d = 32'd0;
            bus_sel_d   = 4'b1111;
          end else if (d_elig) begin
            state_d     = ST_D_ACT;
            tmo_d       = 16'd0;
            bus_req_d   = 1'b1;
            bus_we_d    = i_dbus_we;
            bus_addr_d  = i_dbus_addr;
            bus_wdata_d = i_dbus_wdata;
            bus_sel_d   = i_dbus_sel;
            if (i_elig && starve_q != STARVE_MAX) starve_d = starve_q + 4'd1;
          end
        end
      end
      ST_I_ACT: begin
        if (i_bus_ack) begin
          state_d   = ST_IDLE;
          bus_req_d = 1'b0;
          if (!i_flush) begin
            ibus_data_d = i_bus_rdata;
            ibus_ack_d  = 1'b1;
          end
        end else if (timeout_hit) begin
          state_d    = ST_IDLE;
          bus_req_d  = 1'b0;
          ibus_err_d = !i_flush;
        end else if (i_flush) begin
          // The bus cannot abort, so keep requesting and swallow the reply.
          state_d = ST_I_DROP;
          tmo_d   = 16'd0;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
      ST_D_ACT: begin
        if (i_bus_ack) begin
          state_d      = ST_IDLE;
          bus_req_d    = 1'b0;
          dbus_rdata_d = i_bus_rdata;
          dbus_ack_d   = 1'b1;
        end else if (timeout_hit) begin
          state_d    = ST_IDLE;
          bus_req_d  = 1'b0;
          dbus_err_d = 1'b1;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
      ST_I_DROP: begin
        if (i_bus_ack || timeout_hit) begin
          state_d   = ST_IDLE;
          bus_req_d = 1'b0;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        bus_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q      <= ST_IDLE;
      starve_q     <= 4'd0;
      tmo_q        <= 16'd0;
      bus_req_q    <= 1'b0;
      bus_we_q     <= 1'b0;
      bus_addr_q   <= 30'd0;
      bus_wdata_q  <= 32'd0;
      bus_sel_q    <= 4'd0;
      ibus_data_q  <= 32'd0;
      ibus_ack_q   <= 1'b0;
      ibus_err_q   <= 1'b0;
      dbus_rdata_q <= 32'd0;
      dbus_ack_q   <= 1'b0;
      dbus_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_q     <= starve_d;
      tmo_q        <= tmo_d;
      bus_req_q    <= bus_req_d;
      bus_we_q     <= bus_we_d;
      bus_addr_q   <= bus_addr_d;
      bus_wdata_q  <= bus_wdata_d;
      bus_sel_q    <= bus_sel_d;
      ibus_data_q  <= ibus_data_d;
      ibus_ack_q   <= ibus_ack_d;
      ibus_err_q   <= ibus_err_d;
      dbus_rdata_q <= dbus_rdata_d;
      dbus_ack_q   <= dbus_ack_d;
      dbus_err_q   <= dbus_err_d;
    end
  end

  assign o_ibus_data  = ibus_data_q;
  assign o_ibus_ack   = ibus_ack_q;
  assign o_ibus_err   = ibus_err_q;
  assign o_dbus_rdata = dbus_rdata_q;
  assign o_dbus_ack   = dbus_ack_q;
  assign o_dbus_err   = dbus_err_q;
  assign o_bus_req    = bus_req_q;
  assign o_bus_we     = bus_we_q;
  assign o_bus_addr   = bus_addr_q;
  assign o_bus_wdata  = bus_wdata_q;
  assign o_bus_sel    = bus_sel_q;

endmodule

// File: tb/tb_rv_bus_arbiter.sv
// Directed bench for rv_bus_arbiter: reset, fetch, contention, flush,
// timeout and mid-transaction reset, each scenario in its own task.
module tb_rv_bus_arbiter;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_I_DROP = 2'd3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        ibus_req = 1'b0;
  logic [29:0] ibus_addr = '0;
  logic [31:0] ibus_data;
  logic        ibus_ack, ibus_err;
  logic        dbus_req = 1'b0;
  logic        dbus_we = 1'b0;
  logic [29:0] dbus_addr = '0;
  logic [31:0] dbus_wdata = '0;
  logic [3:0]  dbus_sel = '0;
  logic [31:0] dbus_rdata;
  logic        dbus_ack, dbus_err;
  logic        bus_req, bus_we;
  logic [29:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_sel;
  logic [31:0] bus_rdata = '0;
  logic        bus_ack = 1'b0;

  int tests_run = 0;
  int tests_failed = 0;

  rv_bus_arbiter #(.FETCH_STARVE_MAX(4), .TIMEOUT_CYCLES(8)) dut (
    .i_clk(clk), .i_reset(rst), .i_flush(flush),
    .i_ibus_req(ibus_req), .i_ibus_addr(ibus_addr), .o_ibus_data(ibus_data),
    .o_ibus_ack(ibus_ack), .o_ibus_err(ibus_err),
    .i_dbus_req(dbus_req), .i_dbus_we(dbus_we), .i_dbus_addr(dbus_addr),
    .i_dbus_wdata(dbus_wdata), .i_dbus_sel(dbus_sel), .o_dbus_rdata(dbus_rdata),
    .o_dbus_ack(dbus_ack), .o_dbus_err(dbus_err),
    .o_bus_req(bus_req), .o_bus_we(bus_we), .o_bus_addr(bus_addr),
    .o_bus_wdata(bus_wdata), .o_bus_sel(bus_sel),
    .i_bus_rdata(bus_rdata), .i_bus_ack(bus_ack)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Every cycle's drive and sample point sits 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    tests_run++;
    if ({bus_req, bus_we, bus_addr, bus_wdata, bus_sel} !== '0) begin
      tests_failed++;
      $display("FAIL reset_bus: got req=%b we=%b addr=%h wdata=%h sel=%h want all 0",
               bus_req, bus_we, bus_addr, bus_wdata, bus_sel);
    end
    tests_run++;
    if ({ibus_data, ibus_ack, ibus_err, dbus_rdata, dbus_ack, dbus_err} !== '0) begin
      tests_failed++;
      $display("FAIL reset_ports: got idata=%h iack=%b ierr=%b rdata=%h dack=%b derr=%b want all 0",
               ibus_data, ibus_ack, ibus_err, dbus_rdata, dbus_ack, dbus_err);
    end
    tests_run++;
    if (dut.state_q !== ST_IDLE) begin
      tests_failed++;
      $display("FAIL reset_state: got %0d want %0d", dut.state_q, ST_IDLE);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
  endtask

  task automatic fetch_once(input logic [29:0] addr, input logic [31:0] data);
    ibus_req  = 1'b1;
    ibus_addr = addr;
    tick();
    tests_run++;
    if (bus_req !== 1'b1 || bus_addr !== addr) begin
      tests_failed++;
      $display("FAIL fetch_grant: got req=%b addr=%h want 1 %h", bus_req, bus_addr, addr);
    end
    bus_ack   = 1'b1;
    bus_rdata = data;
    tick();
    bus_ack  = 1'b0;
    ibus_req = 1'b0;
    tests_run++;
    if (ibus_ack !== 1'b1 || ibus_data !== data) begin
      tests_failed++;
      $display("FAIL fetch_done: got ack=%b data=%h want 1 %h", ibus_ack, ibus_data, data);
    end
    tick();
  endtask

  task automatic test_single_fetch();
    ibus_req  = 1'b1;
    ibus_addr = 30'h40;
    tests_run++;
    if (bus_req !== 1'b0) begin
      tests_failed++;
      $display("FAIL sf_cycle0_req: got %b want 0", bus_req);
    end
    tick();
    tests_run++;
    if (bus_req !== 1'b1 || bus_we !== 1'b0 || bus_sel !== 4'hF || bus_addr !== 30'h40) begin
      tests_failed++;
      $display("FAIL sf_cycle1_bus: got req=%b we=%b sel=%h addr=%h want 1 0 f 040",
               bus_req, bus_we, bus_sel, bus_addr);
    end
    bus_ack   = 1'b1;
    bus_rdata = 32'h0050_0093;
    tick();
    bus_ack = 1'b0;
    tests_run++;
    if (ibus_ack !== 1'b1 || ibus_data !== 32'h0050_0093 || bus_req !== 1'b0) begin
      tests_failed++;
      $display("FAIL sf_cycle2_ack: got ack=%b data=%h req=%b want 1 00500093 0",
               ibus_ack, ibus_data, bus_req);
    end
    tick();
    ibus_req = 1'b0;
    tests_run++;
    if (bus_req !== 1'b0 || ibus_ack !== 1'b0) begin
      tests_failed++;
      $display("FAIL sf_no_regrant: got req=%b ack=%b want 0 0", bus_req, ibus_ack);
    end
    tick();
  endtask

  task automatic test_contention();
    logic [9:0] exp_order = 10'h210;
    logic [9:0] got_order = '0;
    int grants = 0;
    ibus_req   = 1'b1;
    ibus_addr  = 30'h80;
    dbus_req   = 1'b1;
    dbus_we    = 1'b1;
    dbus_addr  = 30'h40;
    dbus_wdata = 32'hDEAD_BEEF;
    dbus_sel   = 4'b0011;
    for (int cyc = 0; cyc < 200 && grants < 10; cyc++) begin
      if (bus_req === 1'b1) begin
        got_order[grants] = (bus_sel === 4'hF);
        if (bus_sel !== 4'hF) begin
          tests_run++;
          if (bus_we !== 1'b1 || bus_addr !== 30'h40 || bus_wdata !== 32'hDEAD_BEEF
              || bus_sel !== 4'b0011) begin
            tests_failed++;
            $display("FAIL cont_d_fields: got we=%b addr=%h wdata=%h sel=%h want 1 040 deadbeef 3",
                     bus_we, bus_addr, bus_wdata, bus_sel);
          end
        end
        bus_ack   = 1'b1;
        bus_rdata = 32'h1000_0000 + 32'(grants);
        grants++;
      end else begin
        bus_ack = 1'b0;
      end
      tick();
    end
    bus_ack  = 1'b0;
    ibus_req = 1'b0;
    dbus_req = 1'b0;
    dbus_we  = 1'b0;
    tests_run++;
    if (grants != 10) begin
      tests_failed++;
      $display("FAIL cont_grant_count: got %0d want 10 within cycle budget", grants);
    end
    tests_run++;
    if (got_order !== exp_order) begin
      tests_failed++;
      $display("FAIL cont_order: got %b want %b (bit i = 1 means grant i went to I)",
               got_order, exp_order);
    end
    tick();
    tick();
  endtask

  task automatic test_flush();
    fetch_once(30'h123, 32'hA5A5_0001);
    ibus_req  = 1'b1;
    ibus_addr = 30'h200;
    tick();
    flush     = 1'b1;
    dbus_req  = 1'b1;
    dbus_we   = 1'b0;
    dbus_addr = 30'h33;
    dbus_sel  = 4'hF;
    tick();
    flush    = 1'b0;
    ibus_req = 1'b0;
    tests_run++;
    if (dut.state_q !== ST_I_DROP || bus_req !== 1'b1) begin
      tests_failed++;
      $display("FAIL flush_drop: got state=%0d req=%b want %0d 1", dut.state_q, bus_req, ST_I_DROP);
    end
    tick();
    tests_run++;
    if (bus_req !== 1'b1) begin
      tests_failed++;
      $display("FAIL flush_hold_req: got %b want 1", bus_req);
    end
    bus_ack   = 1'b1;
    bus_rdata = 32'hBAD0_BAD0;
    tick();
    bus_ack = 1'b0;
    tests_run++;
    if (ibus_ack !== 1'b0 || ibus_err !== 1'b0 || ibus_data !== 32'hA5A5_0001 || bus_req !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_discard: got ack=%b err=%b data=%h req=%b want 0 0 a5a50001 0",
               ibus_ack, ibus_err, ibus_data, bus_req);
    end
    tick();
    tests_run++;
    if (bus_req !== 1'b1 || bus_addr !== 30'h33 || bus_we !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_d_next: got req=%b addr=%h we=%b want 1 033 0", bus_req, bus_addr, bus_we);
    end
    bus_ack   = 1'b1;
    bus_rdata = 32'h0D0D_0D0D;
    tick();
    bus_ack  = 1'b0;
    dbus_req = 1'b0;
    tests_run++;
    if (dbus_ack !== 1'b1 || dbus_rdata !== 32'h0D0D_0D0D) begin
      tests_failed++;
      $display("FAIL flush_d_done: got ack=%b rdata=%h want 1 0d0d0d0d", dbus_ack, dbus_rdata);
    end
    tick();
  endtask

  task automatic test_timeout();
    int bad_req = 0;
    dbus_req  = 1'b1;
    dbus_we   = 1'b0;
    dbus_addr = 30'h55;
    dbus_sel  = 4'hF;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (bus_req !== 1'b1 || dbus_err !== 1'b0) bad_req++;
    end
    tests_run++;
    if (bad_req != 0) begin
      tests_failed++;
      $display("FAIL tmo_active: got %0d bad cycles of 8 want 0 (req high, no err)", bad_req);
    end
    tick();
    tests_run++;
    if (dbus_err !== 1'b1 || dbus_ack !== 1'b0 || bus_req !== 1'b0 || dbus_rdata !== 32'h0D0D_0D0D) begin
      tests_failed++;
      $display("FAIL tmo_err: got err=%b ack=%b req=%b rdata=%h want 1 0 0 0d0d0d0d",
               dbus_err, dbus_ack, bus_req, dbus_rdata);
    end
    tick();
    tests_run++;
    if (dbus_err !== 1'b0 || bus_req !== 1'b0) begin
      tests_failed++;
      $display("FAIL tmo_err_pulse: got err=%b req=%b want 0 0", dbus_err, bus_req);
    end
    tick();
    for (int k = 0; k < 7; k++) tick();
    tests_run++;
    if (bus_req !== 1'b1 || dbus_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL tmo_retry_alive: got req=%b err=%b want 1 0", bus_req, dbus_err);
    end
    bus_ack   = 1'b1;
    bus_rdata = 32'h7777_0008;
    tick();
    bus_ack  = 1'b0;
    dbus_req = 1'b0;
    tests_run++;
    if (dbus_ack !== 1'b1 || dbus_err !== 1'b0 || dbus_rdata !== 32'h7777_0008) begin
      tests_failed++;
      $display("FAIL tmo_ack_wins: got ack=%b err=%b rdata=%h want 1 0 77770008",
               dbus_ack, dbus_err, dbus_rdata);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    dbus_req   = 1'b1;
    dbus_we    = 1'b1;
    dbus_addr  = 30'h99;
    dbus_wdata = 32'h1234_5678;
    tick();
    tests_run++;
    if (bus_req !== 1'b1) begin
      tests_failed++;
      $display("FAIL rstmid_active: got req=%b want 1", bus_req);
    end
    #3;
    rst = 1'b1;
    #1;
    tests_run++;
    if ({bus_req, bus_we, bus_addr, bus_wdata, bus_sel, ibus_data, ibus_ack, ibus_err,
         dbus_rdata, dbus_ack, dbus_err} !== '0) begin
      tests_failed++;
      $display("FAIL rstmid_outputs: got req=%b addr=%h wdata=%h idata=%h rdata=%h want all 0",
               bus_req, bus_addr, bus_wdata, ibus_data, dbus_rdata);
    end
    dbus_req = 1'b0;
    dbus_we  = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    tests_run++;
    if (dut.state_q !== ST_IDLE || dbus_ack !== 1'b0 || dbus_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL rstmid_silent: got state=%0d ack=%b err=%b want %0d 0 0",
               dut.state_q, dbus_ack, dbus_err, ST_IDLE);
    end
    fetch_once(30'h0AB, 32'hCAFE_F00D);
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_contention();
    test_flush();
    test_timeout();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
